// File: rtl/nfc_command_getfeature.sv
// nfc_command_getfeature: ONFI GET FEATURES (EEh) sequencer between the way dispatcher and the ACG.
// Optional R/B# wait timeout with oTimeout output when NFC_GETFEATURE_TIMEOUT_EN is defined.
module nfc_command_getfeature #(
    parameter int         NumberOfWays = 4,
    parameter logic [5:0] CommandID    = 6'b000011,
    parameter logic [4:0] TargetID     = 5'b00101
) (
    input  logic                    iSystemClock,
    input  logic                    iReset,
    input  logic [5:0]              iOpcode,
    input  logic                    iCMDValid,
    output logic                    oCMDReady,
    input  logic [NumberOfWays-1:0] iWaySelect,
    input  logic [7:0]              iFeatureAddr,
    output logic                    oStart,
    output logic                    oLastStep,
    output logic [31:0]             oFeature,
    output logic                    oFeatureValid,
`ifdef NFC_GETFEATURE_TIMEOUT_EN
    output logic                    oTimeout,
`endif
    output logic [7:0]              oACG_Command,
    output logic [2:0]              oACG_CommandOption,
    input  logic [7:0]              iACG_Ready,
    input  logic [7:0]              iACG_LastStep,
    output logic [NumberOfWays-1:0] oACG_TargetWay,
    output logic [15:0]             oACG_NumOfData,
    output logic                    oACG_CASelect,
    output logic [39:0]             oACG_CAData,
    input  logic [15:0]             iACG_ReadData,
    input  logic                    iACG_ReadLast,
    input  logic                    iACG_ReadValid,
    output logic                    oACG_ReadReady,
    input  logic [NumberOfWays-1:0] iACG_ReadyBusy
);
    typedef enum logic [3:0] {
        S_RESET, S_READY, S_CMDLatch, S_CMDIssue, S_ADDRIssue,
        S_WaitRBLow, S_WaitRBHigh, S_DATARead, S_Done
    } state_t;
    state_t      rState, wNext;
    logic [7:0]  rFeatureAddr;
    logic        rRB1, rRB2;
    logic [1:0]  rWordCnt;
    logic        wACGReady, wAccept, wBeat, wTimeout, wInWait;
    logic [7:0]  wCommand;
    logic [15:0] wNumOfData;
    logic        wCASelect;
    logic [39:0] wCAData;
    logic        wUnused;
    assign oStart             = (iOpcode == CommandID) & iCMDValid;
    assign wAccept            = (rState == S_READY) & oStart;
    assign wBeat              = iACG_ReadValid & oACG_ReadReady & (rState == S_DATARead);
    assign wInWait            = (rState == S_WaitRBLow) | (rState == S_WaitRBHigh);
    assign wACGReady          = iACG_Ready[6:0] == 7'h7F;
    assign oACG_CommandOption = 3'b000;
    assign wUnused = ^{wACGReady, iACG_Ready[7], iACG_LastStep[7], iACG_LastStep[5],
                       iACG_LastStep[3:0], iACG_ReadLast, TargetID};
`ifdef NFC_GETFEATURE_TIMEOUT_EN
    logic [19:0] rTimer;
    assign wTimeout = wInWait & (rTimer == 20'hFFFFF);
    always_ff @(posedge iSystemClock or posedge iReset)
        if (iReset) begin
            rTimer   <= 20'h0;
            oTimeout <= 1'b0;
        end else begin
            rTimer   <= wInWait ? rTimer + 20'h1 : 20'h0;
            oTimeout <= wTimeout;
        end
`else
    assign wTimeout = 1'b0;
`endif
    always_ff @(posedge iSystemClock or posedge iReset)
        if (iReset) rState <= S_RESET;
        else        rState <= wNext;
    always_comb begin
        wNext = rState;
        case (rState)
            S_RESET:      wNext = S_READY;
            S_READY:      wNext = oStart ? S_CMDLatch : S_READY;
            S_CMDLatch:   wNext = S_CMDIssue;
            S_CMDIssue:   wNext = iACG_LastStep[6] ? S_ADDRIssue : S_CMDIssue;
            S_ADDRIssue:  wNext = iACG_LastStep[6] ? S_WaitRBLow : S_ADDRIssue;
            S_WaitRBLow:  wNext = wTimeout ? S_Done : (!rRB2 ? S_WaitRBHigh : S_WaitRBLow);
            S_WaitRBHigh: wNext = wTimeout ? S_Done : (rRB2 ? S_DATARead : S_WaitRBHigh);
            S_DATARead:   wNext = iACG_LastStep[4] ? S_Done : S_DATARead;
            S_Done:       wNext = S_READY;
            default:      wNext = S_RESET;
        endcase
    end
    // ACG outputs are decoded from the next state so they line up with the state they belong to
    always_comb begin
        wCommand   = (wNext == S_CMDIssue || wNext == S_ADDRIssue) ? 8'h40 :
                     (wNext == S_DATARead) ? 8'h10 : 8'h00;
        wNumOfData = (wNext == S_CMDIssue || wNext == S_ADDRIssue) ? 16'd1 :
                     (wNext == S_DATARead) ? 16'd4 : 16'd0;
        wCASelect  = !(wNext == S_ADDRIssue || wNext == S_DATARead);
        wCAData    = (wNext == S_CMDIssue)  ? {8'hEE, 32'h0} :
                     (wNext == S_ADDRIssue) ? {rFeatureAddr, 32'h0} : 40'h0;
    end
    always_ff @(posedge iSystemClock or posedge iReset)
        if (iReset) begin
            oCMDReady      <= 1'b1;
            oLastStep      <= 1'b0;
            oFeatureValid  <= 1'b0;
            oACG_Command   <= 8'h0;
            oACG_TargetWay <= '0;
            oACG_NumOfData <= 16'h0;
            oACG_CASelect  <= 1'b1;
            oACG_CAData    <= 40'h0;
            oACG_ReadReady <= 1'b0;
            rFeatureAddr   <= 8'h0;
        end else begin
            oCMDReady      <= wNext == S_READY;
            oLastStep      <= wNext == S_Done;
            oFeatureValid  <= (wNext == S_Done && !wTimeout) ? 1'b1 : wAccept ? 1'b0 : oFeatureValid;
            oACG_Command   <= wCommand;
            oACG_TargetWay <= (rState == S_READY || rState == S_CMDLatch) ? iWaySelect : oACG_TargetWay;
            oACG_NumOfData <= wNumOfData;
            oACG_CASelect  <= wCASelect;
            oACG_CAData    <= wCAData;
            oACG_ReadReady <= wNext == S_DATARead;
            rFeatureAddr   <= wAccept ? iFeatureAddr : rFeatureAddr;
        end
    // R/B# passes through two flops before the FSM looks at it
    always_ff @(posedge iSystemClock or posedge iReset)
        if (iReset) begin
            rRB1 <= 1'b0;
            rRB2 <= 1'b0;
        end else begin
            rRB1 <= |(oACG_TargetWay & iACG_ReadyBusy);
            rRB2 <= rRB1;
        end
    always_ff @(posedge iSystemClock or posedge iReset)
        if (iReset) begin
            rWordCnt <= 2'd0;
            oFeature <= 32'h0;
        end else begin
            rWordCnt <= (rState != S_DATARead) ? 2'd0 : (wBeat && rWordCnt != 2'd2) ? rWordCnt + 2'd1 : rWordCnt;
            if (wBeat && rWordCnt == 2'd0) oFeature[31:16] <= iACG_ReadData;
            if (wBeat && rWordCnt == 2'd1) oFeature[15:0]  <= iACG_ReadData;
        end
endmodule
